// File: rtl/rv32i_defs.sv
// Shared RV32I core definitions: write-back state encodings and load funct3 codes.
package rv32i_defs;

  localparam logic [2:0] WB_IDLE   = 3'b000;
  localparam logic [2:0] WB_LDWAIT = 3'b001;
  localparam logic [2:0] WB_WRITE  = 3'b010;
  localparam logic [2:0] WB_DONE   = 3'b011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load data aligner: selects byte/halfword by address offset and extends.
module load_align
  import rv32i_defs::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ofs,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (ofs)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
  end

  // ofs[0] is ignored for halfwords; misaligned halves are not split.
  assign w_half = ofs[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{24{w_byte[7]}}, w_byte};
      F3_LH:   result = {{16{w_half[15]}}, w_half};
      F3_LBU:  result = {24'h000000, w_byte};
      F3_LHU:  result = {16'h0000, w_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/write_back.sv
// Write-back stage: captures the result source on start, waits for load data if needed,
// then issues one register-file write and reports completion.
//
// state     | meaning
// WB_IDLE   | waiting for a start pulse
// WB_LDWAIT | waiting for load data (stall ignored, bounded by LD_TIMEOUT)
// WB_WRITE  | issuing the register-file write (held while stalled)
// WB_DONE   | one-cycle completion pulse
module write_back
  import rv32i_defs::*;
#(
  parameter int LD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        cpu_stat_wb,
  input  logic [4:0]  rd_adr_ma,
  input  logic        rd_wen_ma,
  input  logic        is_load_ma,
  input  logic [2:0]  ld_funct3_ma,
  input  logic [1:0]  ld_adr_ma,
  input  logic [31:0] alu_result_ma,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic        wbk_rd_reg_wb,
  output logic [4:0]  rd_adr_wb,
  output logic [31:0] wbk_data_wb,
  output logic        wb_run,
  output logic        wb_done,
  output logic        ld_timeout_err
);

  localparam logic [3:0] LD_TO = 4'(LD_TIMEOUT);

  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic [4:0]  r_rd_adr;
  logic        r_rd_wen;
  logic [2:0]  r_funct3;
  logic [1:0]  r_ofs;
  logic [31:0] r_data;
  logic        r_err;
  logic [31:0] w_aligned;
  logic        w_start;

  load_align u_load_align (
    .funct3 (r_funct3),
    .ofs    (r_ofs),
    .rdata  (dmem_rdata),
    .result (w_aligned)
  );

  assign w_start = (r_state == WB_IDLE) && cpu_stat_wb && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= WB_IDLE;
      r_cnt    <= 4'd0;
      r_rd_adr <= 5'd0;
      r_rd_wen <= 1'b0;
      r_funct3 <= 3'd0;
      r_ofs    <= 2'd0;
      r_data   <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (w_start) begin
            r_rd_adr <= rd_adr_ma;
            r_rd_wen <= rd_wen_ma;
            r_funct3 <= ld_funct3_ma;
            r_ofs    <= ld_adr_ma;
            r_data   <= alu_result_ma;
            r_err    <= 1'b0;
            r_cnt    <= 4'd0;
            r_state  <= is_load_ma ? WB_LDWAIT : WB_WRITE;
          end
        end
        WB_LDWAIT: begin
          // Arriving data wins over a same-cycle timeout.
          if (dmem_rvalid) begin
            r_data  <= w_aligned;
            r_state <= WB_WRITE;
          end else if (r_cnt == LD_TO) begin
            r_err    <= 1'b1;
            r_rd_wen <= 1'b0;
            r_state  <= WB_WRITE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        WB_WRITE: begin
          if (!stall) r_state <= WB_DONE;
        end
        WB_DONE: r_state <= WB_IDLE;
        default: r_state <= WB_IDLE;
      endcase
    end
  end

  assign wbk_rd_reg_wb  = (r_state == WB_WRITE) && !stall && r_rd_wen && (r_rd_adr != 5'd0);
  assign rd_adr_wb      = r_rd_adr;
  assign wbk_data_wb    = r_data;
  assign wb_done        = (r_state == WB_DONE);
  assign ld_timeout_err = r_err;
  assign wb_run         = ((r_state != WB_IDLE) && (r_state != WB_DONE)) ||
                          (cpu_stat_wb && (r_state == WB_IDLE));

endmodule
